level_ram_ctrl: RTL and testbench

LEVEL_RAM_CTRL -- requirements
Module: level_ram_ctrl

---
 rtl/level_ram_ctrl.sv | 136 +++++++++++++
 tb/tb_level_ram_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_ram_ctrl.sv
// Per-user level counter kept in an external synchronous-read RAM.
// Clears all slots after reset, then serves saturating read-modify-write level-ups.
module level_ram_ctrl #(
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 8,
    parameter int          USER_W    = 4,
    parameter int          NUM_USERS = 4,
    parameter int          BASE_ADDR = 0,
    parameter int unsigned MAX_LEVEL = (32'd1 << DATA_W) - 32'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [USER_W-1:0] user_id,
    input  logic              success,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out,
    output logic              r_w,
    output logic              busy,
    output logic              init_done,
    output logic [DATA_W-1:0] level_out,
    output logic              level_valid,
    output logic              drop
);

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_CALC  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] MAX_L    = DATA_W'(MAX_LEVEL);
    localparam logic [USER_W-1:0] LAST_IDX = USER_W'(NUM_USERS - 1);
    localparam logic [USER_W:0]   USER_LIM = (USER_W + 1)'(NUM_USERS);

    logic [2:0]        state;
    logic [USER_W-1:0] idx;
    logic [USER_W-1:0] slot;
    logic              pend_clr;
    logic              user_ok;
    logic [DATA_W-1:0] next_level;

    always_comb begin
        user_ok    = ({1'b0, user_id} < USER_LIM);
        next_level = (data_in < MAX_L) ? data_in + DATA_W'(1) : MAX_L;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_CLEAR;
            idx         <= '0;
            slot        <= '0;
            pend_clr    <= 1'b0;
            address_out <= BASE_A;
            data_out    <= '0;
            r_w         <= 1'b0;
            busy        <= 1'b1;
            init_done   <= 1'b0;
            level_out   <= '0;
            level_valid <= 1'b0;
            drop        <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            drop        <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    // clear_req here is absorbed; success is still reported as dropped
                    address_out <= BASE_A + ADDR_W'(idx);
                    data_out    <= '0;
                    r_w         <= 1'b1;
                    drop        <= success;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    r_w <= 1'b0;
                    if (clear_req || pend_clr) begin
                        pend_clr <= 1'b0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        drop     <= success;
                        state    <= ST_CLEAR;
                    end else if (success) begin
                        if (user_ok) begin
                            slot        <= user_id;
                            address_out <= BASE_A + ADDR_W'(user_id);
                            busy        <= 1'b1;
                            state       <= ST_READ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    r_w   <= 1'b0;
                    drop  <= success;
                    state <= ST_CALC;
                    if (clear_req) pend_clr <= 1'b1;
                end
                ST_CALC: begin
                    // read data arrives this cycle; the write strobe is registered for WRITE
                    address_out <= BASE_A + ADDR_W'(slot);
                    data_out    <= next_level;
                    r_w         <= 1'b1;
                    level_out   <= next_level;
                    level_valid <= 1'b1;
                    drop        <= success;
                    state       <= ST_WRITE;
                    if (clear_req) pend_clr <= 1'b1;
                end
                ST_WRITE: begin
                    r_w   <= 1'b0;
                    busy  <= 1'b0;
                    drop  <= success;
                    state <= ST_IDLE;
                    if (clear_req) pend_clr <= 1'b1;
                end
                default: begin
                    idx   <= '0;
                    r_w   <= 1'b0;
                    busy  <= 1'b1;
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_ram_ctrl.sv
// Directed bench for level_ram_ctrl with a synchronous-read RAM model.
module tb_level_ram_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] user_id;
    logic       success;
    logic       clear_req;
    logic [7:0] data_in;
    logic [7:0] address_out;
    logic [7:0] data_out;
    logic       r_w;
    logic       busy;
    logic       init_done;
    logic [7:0] level_out;
    logic       level_valid;
    logic       drop;

    always #5 clk = ~clk;

    level_ram_ctrl #(
        .DATA_W(8), .ADDR_W(8), .USER_W(4), .NUM_USERS(4),
        .BASE_ADDR('h10), .MAX_LEVEL(255)
    ) dut (
        .clk(clk), .reset(reset), .user_id(user_id), .success(success),
        .clear_req(clear_req), .data_in(data_in), .address_out(address_out),
        .data_out(data_out), .r_w(r_w), .busy(busy), .init_done(init_done),
        .level_out(level_out), .level_valid(level_valid), .drop(drop)
    );

    logic [7:0]  mem [0:255];
    logic [7:0]  rd_q;
    int unsigned wr_count = 0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [7:0]  pl_data = '0;

    assign data_in = rd_q;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (r_w) begin
            mem[address_out] <= data_out;
            wr_count         <= wr_count + 1;
        end else begin
            rd_q <= mem[address_out];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    int unsigned wr_snap;

    initial begin
        reset     = 1'b0;
        success   = 1'b0;
        clear_req = 1'b0;
        user_id   = '0;
        @(negedge clk);
        for (int a = 'h10; a < 'h14; a++) preload(8'(a), 8'hAA);

        chk("rst_addr", 32'(address_out), 32'h10);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_rw", 32'(r_w), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_init", 32'(init_done), 32'd0);
        chk("rst_lvl", 32'(level_out), 32'h0);
        chk("rst_lv", 32'(level_valid), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);

        // Initial sweep
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sw_rw", 32'(r_w), 32'd1);
            chk("sw_addr", 32'(address_out), 32'h10 + 32'(k));
            chk("sw_data", 32'(data_out), 32'h0);
        end
        tick();
        chk("sw_init", 32'(init_done), 32'd1);
        chk("sw_busy", 32'(busy), 32'd0);
        chk("sw_idle_rw", 32'(r_w), 32'd0);
        chk("sw_mem10", 32'(mem['h10]), 32'h0);
        chk("sw_mem13", 32'(mem['h13]), 32'h0);
        chk("sw_wrcnt", wr_count, 32'd4);

        // Normal update: user 2, RAM 5 -> 6
        preload(8'h12, 8'd5);
        user_id = 4'd2;
        success = 1'b1;
        tick();
        success = 1'b0;
        chk("u2_rd_addr", 32'(address_out), 32'h12);
        chk("u2_rd_rw", 32'(r_w), 32'd0);
        chk("u2_busy", 32'(busy), 32'd1);
        tick();
        chk("u2_calc_rw", 32'(r_w), 32'd0);
        chk("u2_calc_lv", 32'(level_valid), 32'd0);
        tick();
        chk("u2_wr_rw", 32'(r_w), 32'd1);
        chk("u2_wr_addr", 32'(address_out), 32'h12);
        chk("u2_wr_data", 32'(data_out), 32'd6);
        chk("u2_lvl", 32'(level_out), 32'd6);
        chk("u2_lv", 32'(level_valid), 32'd1);
        tick();
        chk("u2_mem", 32'(mem['h12]), 32'd6);
        chk("u2_lv_off", 32'(level_valid), 32'd0);
        chk("u2_idle", 32'(busy), 32'd0);
        chk("u2_wrcnt", wr_count, 32'd5);

        // Saturation at MAX_LEVEL
        preload(8'h11, 8'd255);
        user_id = 4'd1;
        success = 1'b1;
        tick();
        success = 1'b0;
        tick();
        tick();
        chk("sat_rw", 32'(r_w), 32'd1);
        chk("sat_addr", 32'(address_out), 32'h11);
        chk("sat_data", 32'(data_out), 32'd255);
        chk("sat_lvl", 32'(level_out), 32'd255);
        tick();
        chk("sat_mem", 32'(mem['h11]), 32'd255);

        // Out-of-range user is dropped
        user_id = 4'd7;
        success = 1'b1;
        tick();
        success = 1'b0;
        chk("oor_drop", 32'(drop), 32'd1);
        chk("oor_busy", 32'(busy), 32'd0);
        chk("oor_rw", 32'(r_w), 32'd0);
        tick();
        chk("oor_drop_off", 32'(drop), 32'd0);
        chk("oor_wrcnt", wr_count, 32'd6);

        // Second success while busy is dropped
        user_id = 4'd3;
        success = 1'b1;
        tick();
        user_id = 4'd0;
        tick();
        success = 1'b0;
        chk("busy_drop", 32'(drop), 32'd1);
        tick();
        chk("busy_drop_off", 32'(drop), 32'd0);
        chk("busy_wr_addr", 32'(address_out), 32'h13);
        chk("busy_wr_data", 32'(data_out), 32'd1);
        tick();
        chk("busy_mem13", 32'(mem['h13]), 32'd1);
        chk("busy_mem10", 32'(mem['h10]), 32'd0);
        chk("busy_wrcnt", wr_count, 32'd7);

        // Clear requested during CALC of a user-0 update
        user_id = 4'd0;
        success = 1'b1;
        tick();
        success = 1'b0;
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("pc_wr_rw", 32'(r_w), 32'd1);
        chk("pc_wr_addr", 32'(address_out), 32'h10);
        chk("pc_wr_data", 32'(data_out), 32'd1);
        tick();
        chk("pc_idle_busy", 32'(busy), 32'd0);
        chk("pc_mem10", 32'(mem['h10]), 32'd1);
        tick();
        chk("pc_clr_busy", 32'(busy), 32'd1);
        chk("pc_clr_rw", 32'(r_w), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
            chk("pc_sw_rw", 32'(r_w), 32'd1);
            chk("pc_sw_addr", 32'(address_out), 32'h10 + 32'(k));
        end
        tick();
        chk("pc_done_busy", 32'(busy), 32'd0);
        chk("pc_init_kept", 32'(init_done), 32'd1);
        chk("pc_mem10_zero", 32'(mem['h10]), 32'h0);
        chk("pc_mem13_zero", 32'(mem['h13]), 32'h0);
        tick();
        chk("pc_no_restart", 32'(busy), 32'd0);

        // Reset during CALC abandons the update
        preload(8'h11, 8'd9);
        user_id = 4'd1;
        success = 1'b1;
        tick();
        success = 1'b0;
        tick();
        wr_snap = wr_count;
        reset = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd1);
        chk("mr_rw", 32'(r_w), 32'd0);
        chk("mr_addr", 32'(address_out), 32'h10);
        chk("mr_init", 32'(init_done), 32'd0);
        chk("mr_lv", 32'(level_valid), 32'd0);
        @(negedge clk);
        tick();
        chk("mr_nowrite", wr_count, wr_snap);
        chk("mr_mem11", 32'(mem['h11]), 32'd9);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_sw_addr", 32'(address_out), 32'h10 + 32'(k));
            if (k < 3) chk("mr_sw_init", 32'(init_done), 32'd0);
        end
        tick();
        chk("mr_done_init", 32'(init_done), 32'd1);
        chk("mr_done_busy", 32'(busy), 32'd0);
        chk("mr_mem11_zero", 32'(mem['h11]), 32'h0);
        chk("mr_wrcnt", wr_count, wr_snap + 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
